// File: rtl/poly_chord_player.sv
// poly_chord_player: allocates incoming notes to NUM_VOICES voice slots,
// counts each note's remaining duration in beats, drives the per-voice
// note players and mixes their samples into one attenuated output sample.
module poly_chord_player #(
  parameter int NUM_VOICES   = 4,
  parameter int SAMPLE_WIDTH = 16,
  parameter int NOTE_WIDTH   = 6,
  parameter int DUR_WIDTH    = 6,
  parameter int MIX_WIDTH    = SAMPLE_WIDTH + 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               play_enable,
  input  logic                               activate,
  input  logic                               load_new_note,
  input  logic [NOTE_WIDTH-1:0]              note_to_load,
  input  logic [DUR_WIDTH-1:0]               duration,
  input  logic                               beat,
  input  logic                               generate_next_sample,
  input  logic [1:0]                         weight,
  input  logic [NUM_VOICES*SAMPLE_WIDTH-1:0] voice_sample,
  input  logic [NUM_VOICES-1:0]              voice_ready,
  output logic [NUM_VOICES*NOTE_WIDTH-1:0]   voice_note,
  output logic [NUM_VOICES-1:0]              voice_load,
  output logic [NUM_VOICES-1:0]              voice_active,
  output logic [NUM_VOICES-1:0]              voice_gen,
  output logic [MIX_WIDTH-1:0]               final_sample,
  output logic                               sample_ready,
  output logic                               note_done,
  output logic                               voices_full
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SUM  = 2'd2,
    S_OUT  = 2'd3
  } mix_state_t;

  // ---------------------------------------------------------------------
  // Voice allocation and duration tracking
  // ---------------------------------------------------------------------
  logic                  run;
  logic                  beat_dec;
  logic                  load_ok;
  logic [DUR_WIDTH-1:0]  count_reg  [NUM_VOICES];
  logic [DUR_WIDTH-1:0]  count_next [NUM_VOICES];
  logic [NOTE_WIDTH-1:0] note_reg   [NUM_VOICES];
  logic                  active_reg [NUM_VOICES];
  logic                  load_reg   [NUM_VOICES];
  logic [NUM_VOICES-1:0] load_sel;
  logic                  free_found;
  logic [IDX_W-1:0]      free_idx;
  logic [IDX_W-1:0]      steal_idx;
  logic [DUR_WIDTH-1:0]  steal_min;
  logic [IDX_W-1:0]      target_idx;
  logic                  any_now;
  logic                  any_next;

  assign run      = activate & play_enable;
  assign beat_dec = beat & run;
  // Rests and zero-length notes never claim a voice.
  assign load_ok  = load_new_note && (note_to_load != '0) && (duration != '0);

  // Pick the lowest free voice; otherwise steal the one closest to expiry
  // (strict compare keeps ties on the lowest index). Uses pre-decrement counts.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    steal_idx  = '0;
    steal_min  = count_reg[0];
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!free_found && (count_reg[i] == '0)) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (count_reg[i] < steal_min) begin
        steal_min = count_reg[i];
        steal_idx = IDX_W'(i);
      end
    end
  end

  assign target_idx = free_found ? free_idx : steal_idx;

  // Detect whether any voice will still be sounding after this cycle.
  always_comb begin
    any_next = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (count_next[i] != '0) any_next = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
      assign load_sel[gi] = load_ok && (target_idx == IDX_W'(gi));

      // A freshly loaded voice takes its full duration, skipping this beat.
      assign count_next[gi] = load_sel[gi] ? duration :
                              (beat_dec && (count_reg[gi] != '0)) ? count_reg[gi] - 1'b1 :
                              count_reg[gi];

      // Per-voice count, note, activity flag and load pulse.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          count_reg[gi]  <= '0;
          note_reg[gi]   <= '0;
          active_reg[gi] <= 1'b0;
          load_reg[gi]   <= 1'b0;
        end else begin
          count_reg[gi]  <= count_next[gi];
          active_reg[gi] <= (count_next[gi] != '0);
          load_reg[gi]   <= load_sel[gi];
          if (load_sel[gi]) begin
            note_reg[gi] <= note_to_load;
          end
        end
      end

      assign voice_note[gi*NOTE_WIDTH +: NOTE_WIDTH] = note_reg[gi];
      assign voice_active[gi] = active_reg[gi];
      assign voice_load[gi]   = load_reg[gi];
    end
  endgenerate

  assign any_now     = |voice_active;
  assign voices_full = &voice_active;

  // Pulse when the last sounding voice runs out; a steal always leaves a
  // voice loaded, so it can never produce this pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      note_done <= 1'b0;
    end else begin
      note_done <= any_now && !any_next;
    end
  end

  // ---------------------------------------------------------------------
  // Mixer
  // ---------------------------------------------------------------------
  mix_state_t                   state_reg;
  mix_state_t                   state_next;
  logic [NUM_VOICES-1:0]        mask_reg;
  logic [NUM_VOICES-1:0]        flags_reg;
  logic [NUM_VOICES-1:0]        flags_wait;
  logic [IDX_W-1:0]             idx_reg;
  logic signed [MIX_WIDTH-1:0]  acc_reg;
  logic signed [MIX_WIDTH-1:0]  sum_term;
  logic [SAMPLE_WIDTH-1:0]      lat_sample [NUM_VOICES];
  logic                         gen_fire;
  logic                         wait_cap;
  logic                         sum_step;
  logic                         out_fire;

  // Ready pulses only count for voices in the latched mask.
  assign flags_wait = flags_reg | (voice_ready & mask_reg);

  // Mixer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Mixer next-state; losing activate or play_enable aborts to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (generate_next_sample) state_next = S_WAIT;
      S_WAIT: if (flags_wait == mask_reg) state_next = S_SUM;
      S_SUM:  if (idx_reg == LAST_IDX) state_next = S_OUT;
      S_OUT:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (!run) state_next = S_IDLE;
  end

  // Mixer output decode: one strobe per state, all gated by run.
  always_comb begin
    gen_fire = 1'b0;
    wait_cap = 1'b0;
    sum_step = 1'b0;
    out_fire = 1'b0;
    if (run) begin
      case (state_reg)
        S_IDLE:  gen_fire = generate_next_sample;
        S_WAIT:  wait_cap = 1'b1;
        S_SUM:   sum_step = 1'b1;
        S_OUT:   out_fire = 1'b1;
        default: ;
      endcase
    end
  end

  // Select the sign-extended sample for the current summing slot.
  always_comb begin
    sum_term = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if ((idx_reg == IDX_W'(i)) && mask_reg[i]) begin
        sum_term = {{(MIX_WIDTH-SAMPLE_WIDTH){lat_sample[i][SAMPLE_WIDTH-1]}}, lat_sample[i]};
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_capture
      // Keep only the first ready pulse per voice during a mix.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          lat_sample[gi] <= '0;
        end else if (wait_cap && voice_ready[gi] && mask_reg[gi] && !flags_reg[gi]) begin
          lat_sample[gi] <= voice_sample[gi*SAMPLE_WIDTH +: SAMPLE_WIDTH];
        end
      end
    end
  endgenerate

  // Mixer datapath: mask latch, ready flags, accumulator and output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mask_reg     <= '0;
      flags_reg    <= '0;
      idx_reg      <= '0;
      acc_reg      <= '0;
      voice_gen    <= '0;
      final_sample <= '0;
      sample_ready <= 1'b0;
    end else begin
      voice_gen    <= gen_fire ? voice_active : '0;
      sample_ready <= out_fire;
      if (gen_fire) begin
        mask_reg  <= voice_active;
        flags_reg <= '0;
        idx_reg   <= '0;
        acc_reg   <= '0;
      end
      if (wait_cap) begin
        flags_reg <= flags_wait;
      end
      if (sum_step) begin
        acc_reg <= acc_reg + sum_term;
        idx_reg <= idx_reg + 1'b1;
      end
      if (out_fire) begin
        final_sample <= acc_reg >>> weight;
      end
    end
  end

endmodule

// File: tb/tb_poly_chord_player.sv
// Bench for poly_chord_player: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the player.
module tb_poly_chord_player;

  localparam int NV = 4;
  localparam int SW = 16;
  localparam int NW = 6;
  localparam int DW = 6;
  localparam int MW = SW + 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              play_enable;
  logic              activate;
  logic              load_new_note;
  logic [NW-1:0]     note_to_load;
  logic [DW-1:0]     duration;
  logic              beat;
  logic              generate_next_sample;
  logic [1:0]        weight;
  logic [NV*SW-1:0]  voice_sample;
  logic [NV-1:0]     voice_ready;
  logic [NV*NW-1:0]  voice_note;
  logic [NV-1:0]     voice_load;
  logic [NV-1:0]     voice_active;
  logic [NV-1:0]     voice_gen;
  logic [MW-1:0]     final_sample;
  logic              sample_ready;
  logic              note_done;
  logic              voices_full;

  poly_chord_player #(
    .NUM_VOICES(NV), .SAMPLE_WIDTH(SW), .NOTE_WIDTH(NW), .DUR_WIDTH(DW), .MIX_WIDTH(MW)
  ) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .activate(activate),
    .load_new_note(load_new_note), .note_to_load(note_to_load), .duration(duration),
    .beat(beat), .generate_next_sample(generate_next_sample), .weight(weight),
    .voice_sample(voice_sample), .voice_ready(voice_ready), .voice_note(voice_note),
    .voice_load(voice_load), .voice_active(voice_active), .voice_gen(voice_gen),
    .final_sample(final_sample), .sample_ready(sample_ready), .note_done(note_done),
    .voices_full(voices_full)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int            m_cnt  [NV];
  int            m_note [NV];
  int            m_samp [NV];
  logic [NV-1:0] m_load;
  logic [NV-1:0] m_gen;
  logic [NV-1:0] m_mask;
  logic [NV-1:0] m_seen;
  bit            m_done;
  bit            m_srdy;
  bit            m_busy;
  int            m_cd;
  int            m_final;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_cnt[i] = 0; m_note[i] = 0; m_samp[i] = 0;
    end
    m_load = '0; m_gen = '0; m_mask = '0; m_seen = '0;
    m_done = 0; m_srdy = 0; m_busy = 0; m_cd = -1; m_final = 0;
  endtask

  // Apply one clock edge's worth of behaviour using the inputs present now.
  task automatic model_edge();
    int            pre [NV];
    logic [NV-1:0] act_pre;
    bit            run_now;
    bit            any_pre;
    bit            any_post;
    int            tgt;
    int            s;
    run_now = activate && play_enable;
    any_pre = 0;
    for (int i = 0; i < NV; i++) begin
      pre[i] = m_cnt[i];
      act_pre[i] = (pre[i] != 0);
      if (pre[i] != 0) any_pre = 1;
    end
    for (int i = 0; i < NV; i++) begin
      if (beat && run_now && pre[i] > 0) m_cnt[i] = pre[i] - 1;
    end
    m_load = '0;
    if (load_new_note && note_to_load != 0 && duration != 0) begin
      tgt = -1;
      for (int i = 0; i < NV; i++) if (tgt < 0 && pre[i] == 0) tgt = i;
      if (tgt < 0) begin
        tgt = 0;
        for (int i = 1; i < NV; i++) if (pre[i] < pre[tgt]) tgt = i;
      end
      m_cnt[tgt]  = int'(duration);
      m_note[tgt] = int'(note_to_load);
      m_load[tgt] = 1'b1;
    end
    any_post = 0;
    for (int i = 0; i < NV; i++) if (m_cnt[i] != 0) any_post = 1;
    m_done = any_pre && !any_post;

    m_gen  = '0;
    m_srdy = 0;
    if (!run_now) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (generate_next_sample) begin
        m_busy = 1; m_mask = act_pre; m_seen = '0; m_cd = -1; m_gen = act_pre;
      end
    end else if (m_cd < 0) begin
      for (int i = 0; i < NV; i++) begin
        if (voice_ready[i] && m_mask[i] && !m_seen[i]) begin
          m_samp[i] = int'($signed(voice_sample[i*SW +: SW]));
          m_seen[i] = 1'b1;
        end
      end
      if (m_seen == m_mask) m_cd = NV + 1;
    end else begin
      m_cd--;
      if (m_cd == 0) begin
        s = 0;
        for (int i = 0; i < NV; i++) if (m_mask[i]) s += m_samp[i];
        m_final = s >>> weight;
        m_srdy = 1;
        m_busy = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [NV-1:0]    ea;
    logic [NV*NW-1:0] en;
    for (int i = 0; i < NV; i++) begin
      ea[i] = (m_cnt[i] != 0);
      en[i*NW +: NW] = NW'(m_note[i]);
    end
    chk("active", voice_active, ea);
    chk("load", voice_load, m_load);
    chk("note", voice_note, en);
    chk("done", note_done, m_done);
    chk("full", voices_full, &ea);
    chk("gen", voice_gen, m_gen);
    chk("srdy", sample_ready, m_srdy);
    chk("final", $signed(final_sample), m_final);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  // Request one mix, answer with ready_mask one cycle after voice_gen.
  task automatic do_mix(input logic [NV-1:0] ready_mask, output int lat, output int fin);
    lat = -1;
    fin = 0;
    generate_next_sample = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      step();
      generate_next_sample = 1'b0;
      voice_ready = (n == 2) ? ready_mask : '0;
      if (sample_ready === 1'b1 && lat < 0) begin
        lat = n - 1;
        fin = int'($signed(final_sample));
      end
    end
    voice_ready = '0;
  endtask

  int durs [5];
  int ndone;
  int lat;
  int fin;
  int nsr;

  initial begin
    durs = '{20, 8, 4, 6, 2};
    reset = 1'b0; play_enable = 1'b0; activate = 1'b0; load_new_note = 1'b0;
    note_to_load = '0; duration = '0; beat = 1'b0; generate_next_sample = 1'b0;
    weight = '0; voice_sample = '0; voice_ready = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    reset = 1'b1;
    $display("reset: outputs checked");

    // Three-note chord, four beats
    activate = 1'b1; play_enable = 1'b1;
    load_new_note = 1'b1;
    note_to_load = 6'd36; duration = 6'd4; step();
    note_to_load = 6'd32; step();
    note_to_load = 6'd26; step();
    load_new_note = 1'b0;
    step();
    chk("chord_active", voice_active, 4'b0111);
    ndone = 0;
    for (int b = 0; b < 4; b++) begin
      beat = 1'b1; step(); ndone += int'(note_done);
      beat = 1'b0; step(); ndone += int'(note_done);
    end
    chk("chord_done_cnt", ndone, 1);
    chk("chord_idle", voice_active, 4'b0000);
    $display("chord: note_done pulses=%0d", ndone);

    // Five loads into four voices: the fifth steals voice 2
    load_new_note = 1'b1;
    for (int k = 0; k < 5; k++) begin
      note_to_load = NW'(10 + k); duration = DW'(durs[k]); step();
    end
    load_new_note = 1'b0;
    chk("steal_load", voice_load, 4'b0100);
    chk("steal_note", voice_note[2*NW +: NW], 14);
    chk("steal_full", voices_full, 1);
    $display("steal: voice_load=%b voices_full=%b", voice_load, voices_full);

    // Let everything expire
    beat = 1'b1;
    repeat (20) step();
    beat = 1'b0;
    step();

    // Load coinciding with a beat
    load_new_note = 1'b1; note_to_load = 6'd40; duration = 6'd5; step();
    note_to_load = 6'd41; duration = 6'd3; beat = 1'b1; step();
    load_new_note = 1'b0; beat = 1'b0; step();
    for (int b = 0; b < 3; b++) begin
      beat = 1'b1; step(); beat = 1'b0; step();
    end
    chk("beatload_3", voice_active, 4'b0001);
    beat = 1'b1; step(); beat = 1'b0; step();
    chk("beatload_4", voice_active, 4'b0000);
    $display("beat+load: voice_active=%b", voice_active);

    // Three-voice mix, weight 1
    load_new_note = 1'b1; duration = 6'd40;
    note_to_load = 6'd20; step();
    note_to_load = 6'd21; step();
    note_to_load = 6'd22; step();
    load_new_note = 1'b0;
    weight = 2'd1;
    voice_sample[0*SW +: SW] = SW'(1000);
    voice_sample[1*SW +: SW] = SW'(-200);
    voice_sample[2*SW +: SW] = SW'(300);
    voice_sample[3*SW +: SW] = SW'(7777);
    do_mix(4'b0111, lat, fin);
    chk("mix_lat", lat, 7);
    chk("mix_val", fin, 550);
    $display("mix: latency=%0d final=%0d", lat, fin);

    // Drop activate while waiting for readies
    generate_next_sample = 1'b1; step();
    generate_next_sample = 1'b0; activate = 1'b0;
    nsr = 0;
    for (int n = 0; n < 12; n++) begin
      voice_ready = (n == 1) ? 4'b0111 : '0;
      step();
      nsr += int'(sample_ready);
    end
    voice_ready = '0; activate = 1'b1;
    chk("abort_srdy", nsr, 0);
    $display("abort: sample_ready pulses=%0d", nsr);

    // Reset during SUM
    generate_next_sample = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      step();
      generate_next_sample = 1'b0;
      voice_ready = (n == 2) ? 4'b0111 : '0;
    end
    voice_ready = '0;
    reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_final", $signed(final_sample), 0);
    #2;
    reset = 1'b1;
    nsr = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      nsr += int'(sample_ready);
    end
    chk("rst_srdy", nsr, 0);
    $display("reset mid-mix: sample_ready pulses=%0d", nsr);

    // Empty mask mix
    weight = 2'd0;
    do_mix(4'b0000, lat, fin);
    chk("empty_lat", lat, 6);
    chk("empty_val", fin, 0);
    $display("empty mix: latency=%0d final=%0d", lat, fin);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      load_new_note        = ($urandom_range(5, 0) == 0);
      note_to_load         = NW'($urandom_range(63, 0) & ($urandom_range(7, 0) == 0 ? 0 : 63));
      duration             = DW'($urandom_range(12, 0));
      beat                 = ($urandom_range(3, 0) == 0);
      activate             = ($urandom_range(15, 0) != 0);
      play_enable          = ($urandom_range(15, 0) != 0);
      generate_next_sample = ($urandom_range(7, 0) == 0);
      weight               = 2'($urandom_range(3, 0));
      voice_ready          = NV'($urandom_range(15, 0) & $urandom_range(15, 0));
      for (int i = 0; i < NV; i++) voice_sample[i*SW +: SW] = SW'($urandom);
      step();
    end
    $display("random: 3000 cycles");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
